// File: rtl/rs232_tx_seq.sv
// RS-232 packet transmit sequencer: buffers up to BYTE_NUM bytes and hands
// them one frame at a time to an external bit-timing controller.
module rs232_tx_seq #(
   parameter int BYTE_NUM = 8
) (
   input  logic       clk_ref,
   input  logic       rst,
   input  logic       i_wr_en,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_full,
   input  logic       i_send_en,
   output logic       o_rs232_start_en,
   input  logic [3:0] i_ctrl_cnt,
   input  logic       i_rs232_busy,
   input  logic       i_rs232_cfg_over,
   output logic       o_tx,
   output logic [2:0] o_byte_idx,
   output logic       o_seq_busy,
   output logic       o_pkt_done
);

   localparam int AW = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
   localparam int CW = $clog2(BYTE_NUM + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_GAP,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_buf [2**AW];
   logic [CW-1:0] r_wr_cnt;
   logic [CW-1:0] r_pkt_len;
   logic [AW-1:0] r_byte_idx;
   logic [1:0]    r_gap;
   logic          r_tx;

   logic          w_idle;
   logic          w_wr_ok;
   logic          w_send_ok;
   logic          w_last;
   logic          w_tx;
   logic [7:0]    w_byte;
   logic [2:0]    w_bsel;

   assign w_idle    = (r_state == S_IDLE);
   assign w_wr_ok   = i_wr_en && w_idle && (r_wr_cnt < CW'(BYTE_NUM));
   assign w_send_ok = i_send_en && w_idle && (r_wr_cnt != '0);
   assign w_last    = (CW'(r_byte_idx) == (r_pkt_len - CW'(1)));
   assign w_byte    = r_buf[r_byte_idx];
   assign w_bsel    = 3'(i_ctrl_cnt - 4'd1);

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_send_ok) w_state_nxt = S_ARM;
         end
         S_ARM: begin
            if (i_rs232_busy) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_rs232_cfg_over) begin
               w_state_nxt = w_last ? S_DONE : S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap == 2'd2) w_state_nxt = S_ARM;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Line stays high whenever the bit controller is not actively framing.
   always_comb begin
      w_tx = 1'b1;
      if (!w_idle && i_rs232_busy) begin
         if (i_ctrl_cnt == 4'd0) begin
            w_tx = 1'b0;
         end else if (i_ctrl_cnt <= 4'd8) begin
            w_tx = w_byte[w_bsel];
         end
      end
   end

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         r_wr_cnt   <= '0;
         r_pkt_len  <= '0;
         r_byte_idx <= '0;
         r_gap      <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx <= w_tx;
         if (w_wr_ok) begin
            r_wr_cnt <= r_wr_cnt + CW'(1);
         end
         if (w_send_ok) begin
            r_pkt_len  <= r_wr_cnt;
            r_byte_idx <= '0;
         end
         if (r_state == S_WAIT && i_rs232_cfg_over && !w_last) begin
            r_byte_idx <= r_byte_idx + AW'(1);
            r_gap      <= '0;
         end
         if (r_state == S_GAP) begin
            r_gap <= r_gap + 2'd1;
         end
         if (r_state == S_DONE) begin
            r_wr_cnt   <= '0;
            r_byte_idx <= '0;
         end
      end
   end

   // Packet storage carries no reset; only the write pointer matters.
   always_ff @(posedge clk_ref) begin
      if (w_wr_ok) begin
         r_buf[r_wr_cnt[AW-1:0]] <= i_wr_data;
      end
   end

   assign o_wr_full        = (r_wr_cnt == CW'(BYTE_NUM));
   assign o_rs232_start_en = (r_state == S_ARM);
   assign o_seq_busy       = (r_state == S_ARM) || (r_state == S_WAIT) ||
                             (r_state == S_GAP);
   assign o_pkt_done       = (r_state == S_DONE);
   assign o_byte_idx       = 3'(r_byte_idx);
   assign o_tx             = r_tx;

endmodule
